// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: shared state encoding, op codes and round-robin pick helper
package axi_lite_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FAULT} arb_state_t;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  function automatic logic [3:0] rr_pick(input logic [15:0] req_vec, input logic [3:0] last, input int unsigned n);
    logic [3:0] pick;
    int unsigned j;
    pick = '0;
    for (int unsigned k = 16; k >= 1; k--) begin
      j = (32'(last) + k) % n;
      if (k <= n && req_vec[j]) pick = j[3:0];
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner
module rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  logic [3:0] pick;
  assign pick    = rr_pick(16'(req_i), 4'(last_i), N);
  assign idx_o   = IW'(pick);
  assign valid_o = |req_i;
endmodule

// File: rtl/axi_lite_req_arbiter.sv
// axi_lite_req_arbiter: round-robin sharing of one axi_lite_master command port
// with a per-transaction watchdog that latches a sticky fault.
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          start_write,
  output logic                          start_read,
  output logic [ADDR_WIDTH-1:0]         addr_in,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          done_write,
  input  logic                          done_read,
  input  logic [DATA_WIDTH-1:0]         data_out,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t       state_q;
  logic [IDX_W-1:0] last_q, pick;
  logic [CW-1:0]    cnt_q;
  logic             pick_v, op_q, match;
  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .valid_o(pick_v),
    .idx_o  (pick)
  );
  // a done of the other type never completes the transaction
  assign match = (op_q == OP_WRITE) ? done_write : done_read;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      op_q        <= OP_READ;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      addr_in     <= '0;
      data_in     <= '0;
      busy        <= 1'b0;
      grant_idx   <= '0;
      fault       <= 1'b0;
    end else begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      case (state_q)
        IDLE: if (pick_v) begin
          grant_idx       <= pick;
          op_q            <= req_write[pick];
          addr_in         <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          data_in         <= req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          req_ready[pick] <= 1'b1;
          busy            <= 1'b1;
          state_q         <= ISSUE;
        end
        ISSUE: begin
          start_write <= op_q == OP_WRITE;
          start_read  <= op_q == OP_READ;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: if (match) begin
          rsp_rdata            <= (op_q == OP_READ) ? data_out : '0;
          rsp_err              <= 1'b0;
          rsp_valid[grant_idx] <= 1'b1;
          state_q              <= RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_rdata            <= '0;
          rsp_err              <= 1'b1;
          fault                <= 1'b1;
          rsp_valid[grant_idx] <= 1'b1;
          state_q              <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: begin
          last_q  <= grant_idx;
          busy    <= fault;
          state_q <= fault ? FAULT : IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// tb_axi_lite_req_arbiter: randomized transactions checked against a round-robin reference model
module tb_axi_lite_req_arbiter;
  localparam int N = 4;
  localparam int TO = 15;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata, addr_in, data_in, data_out = '0;
  logic rsp_err, start_write, start_read, done_write = 0, done_read = 0, busy, fault;
  logic [1:0] grant_idx;
  int checks = 0, errors = 0, last = N - 1;
  logic [31:0] am [N], dm [N];
  logic [N-1:0] wr;

  axi_lite_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .start_write(start_write), .start_read(start_read), .addr_in(addr_in),
    .data_in(data_in), .done_write(done_write), .done_read(done_read), .data_out(data_out),
    .busy(busy), .grant_idx(grant_idx), .fault(fault));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic chk_reset();
    chk("rst_ready", req_ready, 0); chk("rst_rsp", rsp_valid, 0); chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0); chk("rst_sw", start_write, 0); chk("rst_sr", start_read, 0);
    chk("rst_addr", addr_in, 0); chk("rst_data", data_in, 0); chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0); chk("rst_fault", fault, 0);
  endtask

  task automatic drive_req(input logic [N-1:0] vec);
    @(negedge clk);
    req_valid = vec; req_write = wr;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32] = am[i]; req_wdata[i*32 +: 32] = dm[i];
    end
  endtask

  task automatic wait_grant(input int w);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 8);
    chk("req_ready", req_ready, 64'(1) << w);
    chk("grant_idx", grant_idx, w);
    req_valid = '0;
    @(negedge clk);
    chk("start_write", start_write, wr[w]);
    chk("start_read", start_read, !wr[w]);
    chk("addr_in", addr_in, am[w]);
    chk("data_in", data_in, dm[w]);
  endtask

  task automatic run_txn(input logic [N-1:0] vec, input int dly, input bit wrong, input logic [31:0] rd);
    int w;
    w = model_pick(vec);
    drive_req(vec);
    wait_grant(w);
    if (wrong) begin
      if (wr[w]) done_read = 1; else done_write = 1;
      @(negedge clk);
      done_read = 0; done_write = 0;
      chk("wrong_done", rsp_valid, 0);
    end
    repeat (dly) @(negedge clk);
    data_out = rd;
    if (wr[w]) done_write = 1; else done_read = 1;
    @(negedge clk);
    done_read = 0; done_write = 0; data_out = $urandom;
    chk("rsp_valid", rsp_valid, 64'(1) << w);
    chk("rsp_rdata", rsp_rdata, wr[w] ? 32'h0 : rd);
    chk("rsp_err", rsp_err, 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    last = w;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    int w, n;
    for (int i = 0; i < N; i++) begin am[i] = $urandom; dm[i] = $urandom; end
    wr = '0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 0;
    am[1] = 32'h40; wr = 4'b0000;
    run_txn(4'b0010, 2, 0, 32'hDEADBEEF);
    am[3] = 32'h10; dm[3] = 32'h12345678; wr = 4'b1000;
    run_txn(4'b1000, 5, 0, 32'hCAFEF00D);
    rst = 1; @(negedge clk); rst = 0; last = N - 1;
    for (int i = 0; i < 6; i++) begin
      wr = 4'($urandom);
      run_txn(4'hF, i % 3, i == 2, $urandom);
    end
    for (int i = 0; i < 40; i++) begin
      wr = 4'($urandom);
      for (int j = 0; j < N; j++) begin am[j] = $urandom; dm[j] = $urandom; end
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(0, 3) == 0, $urandom);
    end
    wr = 4'b0000;
    drive_req(4'b0100);
    wait_grant(model_pick(4'b0100));
    @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    chk_reset();
    last = N - 1;
    run_txn(4'hF, 1, 0, $urandom);
    wr = 4'b0000;
    w = model_pick(4'b0110);
    drive_req(4'b0110);
    wait_grant(w);
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == 0 && n < 40);
    chk("to_latency", n, TO + 1);
    chk("to_rsp", rsp_valid, 64'(1) << w);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_fault", fault, 1);
    req_valid = 4'hF;
    repeat (10) begin
      @(negedge clk);
      chk("fault_ready", req_ready, 0);
      chk("fault_start", {start_read, start_write}, 0);
      chk("fault_busy", busy, 1);
    end
    req_valid = '0;
    rst = 1; @(negedge clk); rst = 0;
    chk_reset();
    last = N - 1;
    run_txn(4'hF, 3, 0, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
Shares one axi_lite_master command port among NUM_REQ local requesters. Each requester posts a single-beat read or write command. The block picks one command by round-robin, launches it on the master's start_write/start_read/addr_in/data_in controls, and waits for done_write/done_read. It then returns read data or a completion to the winning requester. A per-transaction watchdog detects a hung bus and latches a sticky fault.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_WIDTH, 32, address width, equals the master's ADDR_WIDTH
DATA_WIDTH, 32, data width, equals the master's DATA_WIDTH
TIMEOUT, 1023, max cycles spent in WAIT before fault (>=1)
IDX_W, $clog2(NUM_REQ), derived, width of a requester index

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has a pending command
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed; slice i = requester i address
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: command i accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: command i complete
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  completion was a timeout, valid with rsp_valid
start_write  out  1  to master, 1-cycle pulse
start_read  out  1  to master, 1-cycle pulse
addr_in  out  ADDR_WIDTH  to master, held from ISSUE to RESP
data_in  out  DATA_WIDTH  to master, held from ISSUE to RESP
done_write  in  1  from master, write complete
done_read  in  1  from master, read complete
data_out  in  DATA_WIDTH  from master, valid while done_read=1
busy  out  1  state != IDLE
grant_idx  out  IDX_W  index of the current or last winner
fault  out  1  sticky watchdog fault

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority; watchdog count=0.
- IDLE: if any req_valid, select the first set bit scanning from last_grant+1, wrapping modulo NUM_REQ.
  - Latch op, addr and wdata of the winner; set grant_idx.
  - Pulse req_ready[winner]; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: pulse start_write (op=1) or start_read (op=0) for exactly one cycle; addr_in/data_in are stable. Clear the count; go to WAIT.
- WAIT: count increments each cycle.
  - done_write with op=write, or done_read with op=read: capture data_out into rsp_rdata (reads only; writes leave rsp_rdata=0); rsp_err=0; go to RESP.
  - A done of the wrong type is ignored.
  - count==TIMEOUT with no matching done: rsp_err=1, rsp_rdata=0; set fault; go to RESP.
- RESP: pulse rsp_valid[grant_idx]; last_grant<=grant_idx. Go to FAULT if fault=1, otherwise IDLE.
- FAULT: terminal until rst. No req_ready, no start pulses; busy=1.
- Latency:
  - req_valid high in IDLE -> req_ready on the next edge.
  - start_* one cycle later.
  - rsp_valid one cycle after the matching done.
  - Minimum turnaround is 4 cycles plus master time.
- Requesters keep req_valid, addr and data stable until req_ready. req_valid deasserting before grant withdraws the request (legal).
- A requester with a response pending may re-request immediately. It competes normally and gets no preference.
- Simultaneous requests: exactly one is granted. Losers wait; every requester is served within NUM_REQ grants.
- done_* arriving in IDLE, ISSUE or RESP is ignored.
- rst mid-transaction returns to reset values immediately. The owner also resets the master.

Decomposition:
- Package axi_lite_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP, FAULT}
  - OP_READ/OP_WRITE constants
  - a function rr_pick(req_vec, last) returning the index.
- One sub-module, rr_arbiter (parameter N): combinational round-robin pick, returning a valid flag and an index. Everything else lives in the top.

Test Plan:
- Single read: NUM_REQ=4, req_valid=4'b0010, addr=0x40, master returns data_out=0xDEADBEEF with done_read -> req_ready=4'b0010, start_read 2 cycles after request, addr_in=0x40, rsp_valid=4'b0010, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Single write: req 3 writes 0x1234_5678 to 0x10, done_write after 5 cycles -> start_write=1 once, data_in=0x12345678, rsp_valid=4'b1000, rsp_rdata=0.
- Fairness: all four req_valid held continuously, each completing -> grant order 0,1,2,3,0,1; no index repeats before all have been served.
- Wrong-type done: read in flight, master pulses done_write -> no rsp_valid; a later done_read completes normally.
- Timeout: TIMEOUT=15, read issued, master never responds -> rsp_valid 16 cycles after entering WAIT with rsp_err=1, fault=1; further req_valid never gets req_ready.
- Reset mid-op: rst asserted in WAIT -> next edge all outputs 0 and fault=0; a new request is served, starting with requester 0 priority.
